// File: rtl/fetch_redirect_unit.sv
// IF-stage PC register and IF/ID pipeline register; redirects fetch on an ID-stage
// taken branch, squashes the wrong-path instruction, honours stalls, counts flushes.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_flag,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      instr_in,
    output logic [31:0]      pc,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc_plus4,
    output logic             ifid_valid,
    output logic             flush_pulse,
    output logic             misalign_err,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       dbgState
);

    // Encoding is visible on dbgState: BOOT=0, RUN=1, FLUSH=2.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pcPlus4;
    logic        doAdvance;
    logic        doRedirect;
    logic        targetMisaligned;

    assign pcPlus4          = pc + 32'd4;
    assign targetMisaligned = (branch_target[1:0] != 2'b00);

    // A branch only exists when ID holds a real instruction; stall outranks it.
    always_comb begin
        doAdvance  = 1'b0;
        doRedirect = 1'b0;
        case (state)
            BOOT:    doAdvance = 1'b1;
            RUN: begin
                if (!stall) begin
                    if (branch_flag && ifid_valid) doRedirect = 1'b1;
                    else                           doAdvance  = 1'b1;
                end
            end
            FLUSH:   doAdvance = !stall;
            default: doAdvance = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= 32'd0;
            ifid_valid    <= 1'b0;
            flush_pulse   <= 1'b0;
            misalign_err  <= 1'b0;
            flush_count   <= '0;
        end else begin
            flush_pulse <= 1'b0;
            if (doRedirect) begin
                pc            <= {branch_target[31:2], 2'b00};
                ifid_instr    <= NOP_INSTR;
                ifid_pc_plus4 <= 32'd0;
                ifid_valid    <= 1'b0;
                flush_pulse   <= 1'b1;
                if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
                if (targetMisaligned) misalign_err <= 1'b1;
                state         <= FLUSH;
            end else if (doAdvance) begin
                pc            <= pcPlus4;
                ifid_instr    <= instr_in;
                ifid_pc_plus4 <= pcPlus4;
                ifid_valid    <= 1'b1;
                state         <= RUN;
            end else if (state != RUN && state != FLUSH && state != BOOT) begin
                state <= BOOT;
            end
        end
    end

    assign dbgState = state;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed scenarios plus randomized traffic checked
// against a transaction-level model of the fetch stage.
module tb_fetch_redirect_unit;

    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] instr_in;

    logic [31:0] pc, ifid_instr, ifid_pc_plus4;
    logic        ifid_valid, flush_pulse, misalign_err;
    logic [15:0] flush_count;
    logic [1:0]  dbgState;

    logic [31:0] wPc, wInstr, wPc4;
    logic        wValid, wFlush, wMis;
    logic [15:0] wCnt;
    logic [1:0]  wState;

    logic [31:0] sPc, sInstr, sPc4;
    logic        sValid, sFlush, sMis;
    logic [1:0]  sCnt;
    logic [1:0]  sState;

    int checks = 0;
    int errors = 0;

    // Reference model: what IF/ID should hold after each edge.
    logic [31:0] mPc, mInstr, mPc4;
    logic        mValid, mFlush, mMis, mBoot;
    int          mCnt;

    always #5 clk = ~clk;

    // Instruction memory: word is a tagged copy of its own address.
    assign instr_in = pc ^ SALT;

    fetch_redirect_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_flag(branch_flag),
        .branch_target(branch_target), .instr_in(instr_in), .pc(pc),
        .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
        .flush_pulse(flush_pulse), .misalign_err(misalign_err),
        .flush_count(flush_count), .dbgState(dbgState)
    );

    fetch_redirect_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk), .reset(reset), .stall(stall), .branch_flag(branch_flag),
        .branch_target(branch_target), .instr_in(instr_in), .pc(wPc),
        .ifid_instr(wInstr), .ifid_pc_plus4(wPc4), .ifid_valid(wValid),
        .flush_pulse(wFlush), .misalign_err(wMis),
        .flush_count(wCnt), .dbgState(wState)
    );

    fetch_redirect_unit #(.CNT_W(2)) dutSat (
        .clk(clk), .reset(reset), .stall(stall), .branch_flag(branch_flag),
        .branch_target(branch_target), .instr_in(instr_in), .pc(sPc),
        .ifid_instr(sInstr), .ifid_pc_plus4(sPc4), .ifid_valid(sValid),
        .flush_pulse(sFlush), .misalign_err(sMis),
        .flush_count(sCnt), .dbgState(sState)
    );

    function automatic logic [15:0] expCnt16();
        return (mCnt > 65535) ? 16'hFFFF : 16'(mCnt);
    endfunction

    function automatic logic [1:0] expCnt2();
        return (mCnt > 3) ? 2'd3 : 2'(mCnt);
    endfunction

    // Applies the fetch-stage rules to the inputs present at this edge.
    task automatic model_step();
        if (reset) begin
            mPc = 32'd0; mInstr = 32'd0; mPc4 = 32'd0; mValid = 1'b0;
            mFlush = 1'b0; mMis = 1'b0; mCnt = 0; mBoot = 1'b1;
        end else if (!mBoot && stall) begin
            mFlush = 1'b0;
        end else if (!mBoot && branch_flag && mValid) begin
            mPc = {branch_target[31:2], 2'b00};
            mInstr = 32'd0; mPc4 = 32'd0; mValid = 1'b0; mFlush = 1'b1;
            mCnt = mCnt + 1;
            if (branch_target[1:0] != 2'b00) mMis = 1'b1;
        end else begin
            mInstr = mPc ^ SALT;
            mPc4 = mPc + 32'd4;
            mPc = mPc + 32'd4;
            mValid = 1'b1; mFlush = 1'b0; mBoot = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; branch_flag = 1'b0;
        tick();
        checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'd0); end
        checks++; if (ifid_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h want 0", ifid_instr); end
        checks++; if (ifid_pc_plus4 !== 32'd0) begin errors++; $display("FAIL reset_pc4 got %h want 0", ifid_pc_plus4); end
        checks++; if ({ifid_valid, flush_pulse, misalign_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {ifid_valid, flush_pulse, misalign_err}); end
        checks++; if (flush_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", flush_count); end
        checks++; if (dbgState !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbgState); end
        checks++; if (wPc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_wrap_pc got %h want fffffffc", wPc); end
        reset = 1'b0;
        // Stall and branch asserted during BOOT must be ignored.
        stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h0000_0800;
        tick();
        stall = 1'b0; branch_flag = 1'b0;
        checks++; if (wPc !== 32'd0) begin errors++; $display("FAIL wrap_pc got %h want 0", wPc); end
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL boot_valid got %b want 1", ifid_valid); end
        for (int i = 1; i <= 4; i++) begin
            logic [31:0] want;
            want = 32'(4 * i);
            checks++; if (pc !== want) begin errors++; $display("FAIL run_pc got %h want %h", pc, want); end
            checks++; if (ifid_pc_plus4 !== want) begin errors++; $display("FAIL run_pc4 got %h want %h", ifid_pc_plus4, want); end
            checks++; if (ifid_instr !== ((want - 32'd4) ^ SALT)) begin errors++; $display("FAIL run_instr got %h want %h", ifid_instr, (want - 32'd4) ^ SALT); end
            if (i < 4) tick();
        end
    endtask

    task automatic test_branch();
        while (pc != 32'h20) tick();
        branch_flag = 1'b1; branch_target = 32'h100;
        tick();
        branch_flag = 1'b0;
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL br_pc got %h want 100", pc); end
        checks++; if (ifid_instr !== 32'd0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL br_bubble got %h/%b want 0/0", ifid_instr, ifid_valid); end
        checks++; if (flush_pulse !== 1'b1) begin errors++; $display("FAIL br_pulse got %b want 1", flush_pulse); end
        checks++; if (flush_count !== 16'd1) begin errors++; $display("FAIL br_count got %0d want 1", flush_count); end
        checks++; if (dbgState !== 2'd2) begin errors++; $display("FAIL br_state got %0d want 2", dbgState); end
        tick();
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL br_next_pc got %h want 104", pc); end
        checks++; if (ifid_instr !== (32'h100 ^ SALT)) begin errors++; $display("FAIL br_target_instr got %h want %h", ifid_instr, 32'h100 ^ SALT); end
        checks++; if (flush_pulse !== 1'b0 || ifid_valid !== 1'b1) begin errors++; $display("FAIL br_after got pulse %b valid %b want 0 1", flush_pulse, ifid_valid); end
    endtask

    task automatic test_stall_vs_branch();
        logic [31:0] holdPc, holdInstr;
        holdPc = pc; holdInstr = ifid_instr;
        stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h200;
        tick();
        checks++; if (pc !== holdPc || ifid_instr !== holdInstr) begin errors++; $display("FAIL stall_hold got %h/%h want %h/%h", pc, ifid_instr, holdPc, holdInstr); end
        checks++; if (flush_count !== 16'd1 || flush_pulse !== 1'b0) begin errors++; $display("FAIL stall_count got %0d/%b want 1/0", flush_count, flush_pulse); end
        stall = 1'b0;
        tick();
        branch_flag = 1'b0;
        checks++; if (pc !== 32'h200 || flush_count !== 16'd2) begin errors++; $display("FAIL stall_release got %h/%0d want 200/2", pc, flush_count); end
        tick();
    endtask

    task automatic test_back_to_back();
        // Second cycle lands in the bubble cycle and must not redirect again.
        branch_flag = 1'b1; branch_target = 32'h300;
        tick();
        checks++; if (pc !== 32'h300 || flush_count !== 16'd3) begin errors++; $display("FAIL b2b_first got %h/%0d want 300/3", pc, flush_count); end
        branch_target = 32'h900;
        tick();
        branch_flag = 1'b0;
        checks++; if (pc !== 32'h304 || flush_count !== 16'd3 || ifid_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%0d/%b want 304/3/1", pc, flush_count, ifid_valid); end
        tick();
        checks++; if (pc !== 32'h308) begin errors++; $display("FAIL b2b_third got %h want 308", pc); end
        branch_flag = 1'b1; branch_target = 32'h400;
        tick();
        branch_flag = 1'b0;
        checks++; if (pc !== 32'h400 || flush_count !== 16'd4) begin errors++; $display("FAIL b2b_again got %h/%0d want 400/4", pc, flush_count); end
        tick();
    endtask

    task automatic test_misalign();
        branch_flag = 1'b1; branch_target = 32'h103;
        tick();
        branch_flag = 1'b0;
        checks++; if (pc !== 32'h100 || misalign_err !== 1'b1) begin errors++; $display("FAIL mis_set got %h/%b want 100/1", pc, misalign_err); end
        tick();
        branch_flag = 1'b1; branch_target = 32'h500;
        tick();
        branch_flag = 1'b0;
        tick();
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_sticky got %b want 1", misalign_err); end
        checks++; if (flush_count !== 16'd6) begin errors++; $display("FAIL mis_count got %0d want 6", flush_count); end
        checks++; if (sCnt !== 2'd3) begin errors++; $display("FAIL sat_count got %0d want 3", sCnt); end
    endtask

    task automatic test_reset_in_flush();
        reset = 1'b1; tick(); reset = 1'b0;
        tick(); tick();
        branch_flag = 1'b1; branch_target = 32'h700;
        tick();
        branch_flag = 1'b0;
        checks++; if (dbgState !== 2'd2) begin errors++; $display("FAIL rf_flush_state got %0d want 2", dbgState); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (pc !== 32'd0 || ifid_valid !== 1'b0 || flush_pulse !== 1'b0) begin errors++; $display("FAIL rf_reset got %h/%b/%b want 0/0/0", pc, ifid_valid, flush_pulse); end
        checks++; if (flush_count !== 16'd0 || dbgState !== 2'd0) begin errors++; $display("FAIL rf_state got %0d/%0d want 0/0", flush_count, dbgState); end
        tick();
        checks++; if (pc !== 32'd4) begin errors++; $display("FAIL rf_boot got %h want 4", pc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 3) == 0);
            branch_flag = ($urandom_range(0, 2) == 0);
            branch_target = $urandom();
            if ($urandom_range(0, 4) != 0) branch_target[1:0] = 2'b00;
            tick();
            checks++; if (pc !== mPc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, pc, mPc); end
            checks++; if (ifid_instr !== mInstr) begin errors++; $display("FAIL rnd_instr cyc %0d got %h want %h", i, ifid_instr, mInstr); end
            checks++; if (ifid_pc_plus4 !== mPc4) begin errors++; $display("FAIL rnd_pc4 cyc %0d got %h want %h", i, ifid_pc_plus4, mPc4); end
            checks++; if (ifid_valid !== mValid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, ifid_valid, mValid); end
            checks++; if (flush_pulse !== mFlush) begin errors++; $display("FAIL rnd_pulse cyc %0d got %b want %b", i, flush_pulse, mFlush); end
            checks++; if (misalign_err !== mMis) begin errors++; $display("FAIL rnd_mis cyc %0d got %b want %b", i, misalign_err, mMis); end
            checks++; if (flush_count !== expCnt16()) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, flush_count, expCnt16()); end
            checks++; if (sCnt !== expCnt2()) begin errors++; $display("FAIL rnd_sat cyc %0d got %0d want %0d", i, sCnt, expCnt2()); end
        end
        reset = 1'b0; stall = 1'b0; branch_flag = 1'b0;
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall_vs_branch();
        test_back_to_back();
        test_misalign();
        test_reset_in_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
